// File: rtl/modn_round_counter.sv
// Modulo-N round counter: a start launches a run from S toward T, one step per adv strobe,
// either one-shot (ends in a single-cycle DONE) or free-running with wrap.
module modn_round_counter #(
  parameter int MODULUS = 33,
  parameter int WIDTH   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             adv,
  input  logic             dir,
  input  logic             wrap_en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  if (MODULUS < 2 || (64'd1 << WIDTH) < 64'(MODULUS)) begin : g_param_check
    $error("modn_round_counter: need MODULUS >= 2 and 2**WIDTH >= MODULUS");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] count_nx;
  logic             dir_q, dir_nx, tc_nx;
  logic [WIDTH-1:0] s_val, t_val, step_val;

  // Control inputs are level strobes, not handshakes: start counts only in IDLE,
  // adv only in RUN, and abort (below reset) beats both in any state.
  assign s_val    = dir_q ? LAST : '0;
  assign t_val    = dir_q ? '0 : LAST;
  assign step_val = dir_q ? (count - WIDTH'(1)) : (count + WIDTH'(1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_comb begin
    state_nx = state;
    count_nx = count;
    dir_nx   = dir_q;
    tc_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          dir_nx   = dir;
          count_nx = dir ? LAST : '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (adv) begin
          if (count == t_val) begin
            // Only reachable in wrap mode; S never equals T, so no tc here.
            count_nx = s_val;
          end else begin
            count_nx = step_val;
            if (step_val == t_val) begin
              tc_nx = 1'b1;
              if (!wrap_en) state_nx = DONE;
            end
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      dir_q <= 1'b0;
      tc    <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      dir_q <= dir_nx;
      tc    <= tc_nx;
    end
  end

endmodule

// File: doc/modn_round_counter.md
MODN_ROUND_COUNTER -- requirements
Module: modn_round_counter

Interface
REQ-001 Parameter MODULUS, default 33: number of count states; count range is 0..MODULUS-1.
REQ-002 Parameter WIDTH, default 6: width of count.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: launch request; sampled only in IDLE.
REQ-006 Port adv, input, 1: advance-one-step strobe; sampled only in RUN.
REQ-007 Port dir, input, 1: 0 = count up, 1 = count down; latched at start.
REQ-008 Port wrap_en, input, 1: 1 = free-run with wrap; 0 = one-shot; sampled every RUN cycle.
REQ-009 Port abort, input, 1: cancel the current run.
REQ-010 Port count, output, WIDTH: current count value, registered.
REQ-011 Port busy, output, 1: high while in RUN.
REQ-012 Port done, output, 1: one-cycle completion pulse.
REQ-013 Port tc, output, 1: terminal-count pulse, registered.

Function
REQ-014 The design SHALL fail elaboration unless MODULUS >= 2 and 2^WIDTH >= MODULUS.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 Definitions: start value S = 0 when dir_q = 0 and MODULUS-1 when dir_q = 1; terminal value T = MODULUS-1 when dir_q = 0 and 0 when dir_q = 1; dir_q is the value of dir latched at start.
REQ-017 In IDLE, start=1 and abort=0 SHALL, at the next edge: latch dir into dir_q, load count with S, and enter RUN.
REQ-018 In RUN with adv=0, count SHALL hold.
REQ-019 In RUN with adv=1 and count != T, count SHALL step by +1 (dir_q=0) or -1 (dir_q=1).
REQ-020 In RUN with adv=1 and count == T, count SHALL reload S and the FSM SHALL stay in RUN (reachable only while wrap_en=1).
REQ-021 In RUN, if adv=1, wrap_en=0 and the next count equals T, the FSM SHALL enter DONE with count = T.
REQ-022 For a one-shot run, exactly MODULUS-1 adv strobes SHALL elapse between start acceptance and DONE.
REQ-023 DONE SHALL last exactly one cycle and then go to IDLE; count SHALL hold T through DONE and into IDLE.
REQ-024 done SHALL be 1 exactly while the FSM is in DONE.
REQ-025 busy SHALL be 1 exactly while the FSM is in RUN.
REQ-026 tc SHALL be 1 for exactly the one cycle after any edge that sets count to T while in RUN; this includes the transition into DONE.
REQ-027 start SHALL be ignored in RUN and DONE; a start asserted during DONE takes effect only if it is still high in the following IDLE cycle.
REQ-028 abort=1 in RUN or DONE SHALL force IDLE at the next edge; count holds, done stays 0, and tc is 0 on the next cycle.
REQ-029 Priority SHALL be reset > abort > start/adv; abort=1 with start=1 in IDLE SHALL leave the FSM in IDLE.
REQ-030 count SHALL never leave the range 0..MODULUS-1 under any input sequence.
REQ-031 dir changes during RUN SHALL have no effect until the next start.

Reset
REQ-032 On reset=1 at a clock edge: state IDLE, count 0, dir_q 0, busy 0, done 0, tc 0.
REQ-033 Reset SHALL override any state or input combination, including during RUN or DONE.
REQ-034 No output SHALL change except on a clock edge; there is no asynchronous path.

Verification
REQ-035 Default parameters, dir=0, wrap_en=0, start then adv held high -> count 0,1,...,32; DONE is entered on the 32nd adv; done=1 and tc=1 for one cycle with count=32; then IDLE with busy=0.
REQ-036 dir=1, wrap_en=0, continuous adv -> count 32,31,...,0; done pulses with count=0; tc pulses on the same cycle.
REQ-037 dir=0, wrap_en=1 -> at count=32, tc pulses; the next adv gives count=0, busy stays 1 and done never asserts; then clear wrap_en and run to 32 -> done pulses.
REQ-038 adv toggled 1,0,0,1 from count=5 -> count 6,6,6,7; abort at count=10 -> IDLE, count=10, done=0.
REQ-039 reset asserted in RUN at count=17 -> next cycle count=0, busy=0, done=0, tc=0; start during DONE held one extra cycle -> new run begins from IDLE.
REQ-040 Instance with MODULUS=5, WIDTH=3, up one-shot -> count 0..4, done after 4 adv strobes; instance with MODULUS=8, WIDTH=2 -> elaboration error.
